// File: rtl/count_chk_pkg.sv
// Shared types and defaults for the count sequence checker.
//   chk_state_t  : checker FSM states
//   DEF_LOCK_CNT : default number of consecutive good steps needed to lock
package count_chk_pkg;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,   // no previous sample held yet
      ACQUIRE = 2'd1,   // previous sample held, counting good steps
      LOCKED  = 2'd2    // sequence tracked, wraps and breaks reported
   } chk_state_t;

   localparam int DEF_LOCK_CNT = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear; takes priority over inc
//   inc      : count one event this cycle
//   q        : current count, sticks at all-ones
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (clr)
         q_d = '0;
      else if (inc && (q_q != '1))
         q_d = q_q + ONE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) q_q <= '0;
      else     q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/count_sequence_checker.sv
// Monitors an upstream free-running counter: each enabled sample must equal
// the previous sample plus one (mod 2^WIDTH). Locks after LOCK_CNT good steps,
// then pulses wrap_pulse on max->0 steps and err_pulse on breaks.
//   clk, rst   : clock, asynchronous active-high reset
//   en         : sample strobe, count_in valid when high
//   count_in   : upstream counter value
//   clr        : synchronous clear of err_count / wrap_count
//   locked     : high while in LOCKED
//   wrap_pulse : one-cycle pulse on a locked max->0 step
//   err_pulse  : one-cycle pulse on a sequence break while locked
//   expected   : next value expected (prev+1)
//   err_count  : saturating count of err_pulse events
//   wrap_count : saturating count of wrap_pulse events
module count_sequence_checker
   import count_chk_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int LOCK_CNT = DEF_LOCK_CNT,
   parameter int ERR_W    = 8,
   parameter int WRAP_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [WIDTH-1:0]  count_in,
   input  logic              clr,
   output logic              locked,
   output logic              wrap_pulse,
   output logic              err_pulse,
   output logic [WIDTH-1:0]  expected,
   output logic [ERR_W-1:0]  err_count,
   output logic [WRAP_W-1:0] wrap_count
);

   // LOCK_CNT is limited to 1..15, so a 4-bit good counter always suffices
   localparam int               GW     = 4;
   localparam logic [GW-1:0]    LOCK_V = GW'(LOCK_CNT);
   localparam logic [GW-1:0]    G_ONE  = GW'(1);
   localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
   localparam logic [WIDTH-1:0] MAX    = '1;

   chk_state_t       state_q, state_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic [GW-1:0]    good_q, good_d;
   logic             wrap_q, wrap_d;
   logic             err_q, err_d;
   logic             good_step;

   assign good_step = (count_in == exp_q);

   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      exp_d   = exp_q;
      good_d  = good_q;
      wrap_d  = 1'b0;
      err_d   = 1'b0;
      if (en) begin
         prev_d = count_in;
         exp_d  = count_in + ONE;
         case (state_q)
            EMPTY: begin
               good_d  = '0;
               state_d = ACQUIRE;
            end
            ACQUIRE: begin
               if (good_step) begin
                  good_d = good_q + G_ONE;
                  if ((good_q + G_ONE) == LOCK_V) state_d = LOCKED;
               end else begin
                  good_d = '0;
               end
            end
            LOCKED: begin
               if (good_step) begin
                  wrap_d = (prev_q == MAX);
               end else begin
                  err_d   = 1'b1;
                  good_d  = '0;
                  state_d = ACQUIRE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         prev_q  <= '0;
         exp_q   <= ONE;
         good_q  <= '0;
         wrap_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         exp_q   <= exp_d;
         good_q  <= good_d;
         wrap_q  <= wrap_d;
         err_q   <= err_d;
      end
   end

   assign locked     = (state_q == LOCKED);
   assign wrap_pulse = wrap_q;
   assign err_pulse  = err_q;
   assign expected   = exp_q;

   // counters see the same-cycle event so they update alongside the pulses
   sat_counter #(.W(ERR_W)) u_err_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (err_d),
      .q   (err_count)
   );

   sat_counter #(.W(WRAP_W)) u_wrap_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (wrap_d),
      .q   (wrap_count)
   );

endmodule

// File: tb/tb_count_sequence_checker.sv
module tb_count_sequence_checker;

   localparam int LOCK_CNT = 3;
   localparam int ERR_MAX  = 255;
   localparam int WRAP_MAX = 65535;

   logic        clk, rst, en, clr;
   logic [3:0]  count_in;
   logic        locked, wrap_pulse, err_pulse;
   logic [3:0]  expected;
   logic [7:0]  err_count;
   logic [15:0] wrap_count;

   int checks = 0;
   int failures = 0;

   // reference: a run length of good steps since the last seed or break
   bit m_has;
   int m_prev, m_run, m_errc, m_wrapc;
   bit m_wrap, m_err;

   count_sequence_checker dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .count_in   (count_in),
      .clr        (clr),
      .locked     (locked),
      .wrap_pulse (wrap_pulse),
      .err_pulse  (err_pulse),
      .expected   (expected),
      .err_count  (err_count),
      .wrap_count (wrap_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_has = 0; m_prev = 0; m_run = 0; m_errc = 0; m_wrapc = 0;
      m_wrap = 0; m_err = 0;
   endtask

   task automatic model_step(input bit e, input int v, input bit c);
      bit was_locked, good;
      m_wrap = 0; m_err = 0;
      if (e) begin
         if (!m_has) begin
            m_has = 1; m_run = 0;
         end else begin
            was_locked = (m_run >= LOCK_CNT);
            good = (v == ((m_prev + 1) % 16));
            if (good) begin
               if (was_locked && m_prev == 15) m_wrap = 1;
               if (m_run < 1000) m_run++;
            end else begin
               if (was_locked) m_err = 1;
               m_run = 0;
            end
         end
         m_prev = v;
      end
      if (c) begin
         m_errc = 0; m_wrapc = 0;
      end else begin
         if (m_err  && m_errc  < ERR_MAX)  m_errc++;
         if (m_wrap && m_wrapc < WRAP_MAX) m_wrapc++;
      end
   endtask

   task automatic check_outputs(input string ph);
      check({ph, ".locked"},   32'(locked),     32'(m_has && m_run >= LOCK_CNT));
      check({ph, ".wrap"},     32'(wrap_pulse), 32'(m_wrap));
      check({ph, ".err"},      32'(err_pulse),  32'(m_err));
      check({ph, ".expected"}, 32'(expected),   32'((m_prev + 1) % 16));
      check({ph, ".err_cnt"},  32'(err_count),  32'(m_errc));
      check({ph, ".wrap_cnt"}, 32'(wrap_count), 32'(m_wrapc));
   endtask

   task automatic step(input string ph, input bit e, input int v, input bit c);
      en = e; count_in = 4'(v); clr = c;
      @(posedge clk);
      model_step(e, v, c);
      #1;
      check_outputs(ph);
   endtask

   initial begin
      int v;
      en = 0; count_in = 0; clr = 0; rst = 1;
      model_reset();
      #12;
      check_outputs("reset");
      @(negedge clk); rst = 0;

      // clean count 0..15,0,1
      for (int i = 0; i < 18; i++) step("run", 1, i % 16, 0);
      check("run.wrap_count", 32'(wrap_count), 32'd1);

      // break while locked, then relock
      step("brk", 1, 5, 0); step("brk", 1, 6, 0); step("brk", 1, 9, 0);
      check("brk.expected", 32'(expected), 32'd10);
      for (int i = 10; i < 14; i++) step("relock", 1, i, 0);

      // upstream reset to 0 from a non-max value
      step("urst", 1, 7, 0); step("urst", 1, 0, 0);
      for (int i = 1; i < 5; i++) step("urst", 1, i, 0);

      // en low with junk values
      for (int i = 0; i < 4; i++) step("hold", 0, $urandom_range(0, 15), 0);
      for (int i = 5; i < 9; i++) step("resume", 1, i, 0);

      // force 300 errors to saturate err_count
      v = 8;
      for (int k = 0; k < 300; k++) begin
         for (int j = 0; j < LOCK_CNT; j++) begin
            v = (v + 1) % 16;
            step("sat", 1, v, 0);
         end
         step("sat", 1, v, 0);   // held value breaks the sequence
      end
      check("sat.err_count", 32'(err_count), 32'd255);

      // clr on the same cycle as an error event
      for (int j = 0; j < LOCK_CNT; j++) begin
         v = (v + 1) % 16;
         step("clr", 1, v, 0);
      end
      step("clr", 1, v, 1);
      check("clr.wins", 32'(err_count), 32'd0);

      // async reset between edges while locked
      for (int j = 0; j < 4; j++) begin
         v = (v + 1) % 16;
         step("prearst", 1, v, 0);
      end
      en = 0;
      #2 rst = 1;
      #1;
      model_reset();
      check_outputs("arst");
      @(negedge clk); rst = 0;
      step("reseed", 1, 11, 0);
      for (int j = 12; j < 16; j++) step("reseed", 1, j, 0);

      // randomized traffic, mostly in-sequence
      v = 15;
      for (int i = 0; i < 3000; i++) begin
         bit e, c;
         e = ($urandom_range(0, 9) != 0);
         c = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 9) < 8) v = (v + 1) % 16;
         else v = $urandom_range(0, 15);
         step("rand", e, v, c);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
